fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS core. It owns the enable and next-value inputs of the `pc` register and runs the single-outstanding request/address-ok/data-ok handshake with instruction memory. It holds one fetched instruction in a buffer for decode, and applies exception, eret and branch redirects. It sits between `pc`, the instruction SRAM port and the decode stage.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port between the fetch sequencer and the SRAM:
// one outstanding request, accepted by addr_ok and completed by data_ok.
interface fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_addr_ok;
  logic             imem_data_ok;
  logic [31:0]      imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_addr_ok,
    input  imem_data_ok,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_addr_ok,
    output imem_data_ok,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the pc register, runs the imem handshake,
// buffers one instruction for decode and applies exc/eret/branch redirects.
//
// state | meaning
// BOOT  | after reset; load RESET_PC into pc, no request
// REQ   | present pc_q to imem when the buffer is free or being consumed
// WAIT  | request accepted, waiting for data_ok on the live path
// DROP  | request accepted but redirected; discard its data_ok
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'hBFC00380
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc_q,
  output logic [WIDTH-1:0]   pc_d,
  output logic               pc_en,
  input  logic               exc_valid,
  input  logic               eret_valid,
  input  logic [WIDTH-1:0]   epc,
  input  logic               br_taken,
  input  logic [WIDTH-1:0]   br_target,
  fetch_ctrl_if.master       imem,
  input  logic               stall_i,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [WIDTH-1:0]   inst_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             capture;
  logic             consume;

  // Redirects are meaningless before the boot PC has been loaded.
  assign redirect = (state != BOOT) && (exc_valid || eret_valid || br_taken);
  assign target   = exc_valid  ? EXC_VEC :
                    eret_valid ? epc     : br_target;

  assign consume        = inst_valid && !stall_i;
  assign imem.imem_req  = (state == REQ) && (!inst_valid || !stall_i);
  assign imem.imem_addr = pc_q;
  assign capture        = (state == WAIT) && imem.imem_data_ok && !redirect;

  always_comb begin
    pc_d  = pc_q;
    pc_en = 1'b0;
    if (state == BOOT) begin
      pc_d  = RESET_PC;
      pc_en = 1'b1;
    end else if (redirect) begin
      pc_d  = target;
      pc_en = 1'b1;
    end else if (capture) begin
      pc_d  = pc_q + PC_STEP;
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      if (consume) inst_valid <= 1'b0;
      if (capture) begin
        inst_valid <= 1'b1;
        inst       <= imem.imem_rdata;
        inst_pc    <= pc_q;
      end
      // Wrong-path flush wins over consume; capture never coincides with it.
      if (redirect) inst_valid <= 1'b0;

      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (imem.imem_req && imem.imem_addr_ok)
            state <= redirect ? DROP : WAIT;
        end
        WAIT: begin
          if (imem.imem_data_ok) state <= REQ;
          else if (redirect)     state <= DROP;
        end
        DROP: begin
          if (imem.imem_data_ok) state <= REQ;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: transaction-level reference model plus a
// small SRAM responder and pc register, with directed boundary scenarios first.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] EXC_VEC  = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        exc_valid = 1'b0;
  logic        eret_valid = 1'b0;
  logic [31:0] epc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall_i = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_q       (pc_q),
    .pc_d       (pc_d),
    .pc_en      (pc_en),
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem       (imem_bus),
    .stall_i    (stall_i),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  // The pc register the block drives; resets to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc_q <= '0;
    else if (pc_en) pc_q <= pc_d;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_out tracks the single outstanding request
  // (0 = none, 1 = live, 2 = dead/redirected).
  bit          m_boot;
  int          m_out;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic [31:0] m_pc;

  bit          mb_busy;
  logic [31:0] mb_addr;
  int          mb_cnt;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h11111111;
      32'hBFC00004: return 32'h22222222;
      default:      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk1("inst_valid", inst_valid, m_valid);
    if (m_valid) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_vs_mem", inst, mem_fn(inst_pc));
    end
    chk("pc_q", pc_q, m_pc);
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance model and memory, then check registered outputs at the next fall.
  task automatic step(input bit st, input bit ex, input bit er, input bit br,
                      input logic [31:0] ep, input logic [31:0] bt,
                      input bit aok, input int dly);
    logic [31:0] tgt, e_pcd, rd;
    bit          redir, e_req, e_en, dok;
    stall_i    = st;
    exc_valid  = ex;
    eret_valid = er;
    br_taken   = br;
    epc        = ep;
    br_target  = bt;
    imem_bus.imem_addr_ok = aok;
    dok = mb_busy && (mb_cnt == 0);
    rd  = dok ? mem_fn(mb_addr) : $urandom;
    imem_bus.imem_data_ok = dok;
    imem_bus.imem_rdata   = rd;
    #1;
    redir = !m_boot && (ex || er || br);
    tgt   = ex ? EXC_VEC : (er ? ep : bt);
    e_req = !m_boot && (m_out == 0) && (!m_valid || !st);
    if (m_boot)                     begin e_en = 1'b1; e_pcd = RESET_PC;   end
    else if (redir)                 begin e_en = 1'b1; e_pcd = tgt;        end
    else if ((m_out == 1) && dok)   begin e_en = 1'b1; e_pcd = m_pc + 32'd4; end
    else                            begin e_en = 1'b0; e_pcd = m_pc;       end
    chk1("imem_req", imem_bus.imem_req, e_req);
    chk("imem_addr", imem_bus.imem_addr, m_pc);
    chk1("pc_en", pc_en, e_en);
    chk("pc_d", pc_d, e_pcd);

    if (imem_bus.imem_req && aok) begin
      mb_busy = 1'b1;
      mb_addr = imem_bus.imem_addr;
      mb_cnt  = dly;
    end else if (mb_busy) begin
      if (mb_cnt == 0) mb_busy = 1'b0;
      else             mb_cnt--;
    end

    if (m_valid && !st) m_valid = 1'b0;
    if (e_req && aok) begin
      m_out = redir ? 2 : 1;
    end else if (m_out == 1) begin
      if (dok) begin
        if (!redir) begin
          m_valid = 1'b1;
          m_inst  = rd;
          m_ipc   = m_pc;
        end
        m_out = 0;
      end else if (redir) begin
        m_out = 2;
      end
    end else if ((m_out == 2) && dok) begin
      m_out = 0;
    end
    if (redir) m_valid = 1'b0;
    m_pc   = e_pcd;
    m_boot = 1'b0;

    @(negedge clk);
    check_regs();
  endtask

  task automatic idle(input bit aok, input int dly);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, aok, dly);
  endtask

  // Called at a falling edge; returns at the falling edge where rst drops.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_pc_en", pc_en, 1'b1);
    chk("rst_pc_d", pc_d, RESET_PC);
    chk1("rst_imem_req", imem_bus.imem_req, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    m_boot  = 1'b1;
    m_out   = 0;
    m_valid = 1'b0;
    m_inst  = '0;
    m_ipc   = '0;
    m_pc    = '0;
    mb_busy = 1'b0;
    mb_cnt  = 0;
    mb_addr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    imem_bus.imem_addr_ok = 1'b0;
    imem_bus.imem_data_ok = 1'b0;
    imem_bus.imem_rdata   = '0;
    @(negedge clk);
    do_reset();

    // Boot
    idle(1'b0, 0);
    chk1("boot_req", imem_bus.imem_req, 1'b1);
    chk("boot_addr", imem_bus.imem_addr, 32'hBFC00000);

    // Sequential fetch, zero-wait memory
    idle(1'b1, 0);
    idle(1'b0, 0);
    chk("seq1_inst", inst, 32'h11111111);
    chk("seq1_pc", inst_pc, 32'hBFC00000);
    chk("seq1_pcq", pc_q, 32'hBFC00004);
    idle(1'b1, 0);
    idle(1'b0, 0);
    chk("seq2_inst", inst, 32'h22222222);
    chk("seq2_pc", inst_pc, 32'hBFC00004);

    // Stall holds the buffer and blocks requests even with addr_ok high
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    chk("stall_inst_pc", inst_pc, 32'hBFC00004);
    chk1("stall_req", imem_bus.imem_req, 1'b0);
    idle(1'b0, 0);
    chk1("unstall_req", imem_bus.imem_req, 1'b1);
    chk1("unstall_valid", inst_valid, 1'b0);
    chk("unstall_pcq", pc_q, 32'hBFC00008);

    // Redirect while waiting for data: late data must be dropped
    idle(1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80000100, 1'b0, 0);
    idle(1'b0, 0);
    idle(1'b0, 0);
    chk("drop_pcq", pc_q, 32'h80000100);
    chk1("drop_valid", inst_valid, 1'b0);
    chk1("drop_req", imem_bus.imem_req, 1'b1);
    chk("drop_addr", imem_bus.imem_addr, 32'h80000100);

    // All three redirects together: exception wins
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'h00002000, 1'b0, 0);
    chk("prio_pcq", pc_q, 32'hBFC00380);
    chk1("prio_valid", inst_valid, 1'b0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFC, 1'b0, 0);
    idle(1'b1, 0);
    idle(1'b0, 0);
    chk("wrap_pcq", pc_q, 32'h00000000);
    chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);

    // Reset in the middle of a wait
    idle(1'b1, 3);
    idle(1'b0, 0);
    do_reset();
    idle(1'b0, 0);
    chk("reboot_pcq", pc_q, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        logic [31:0] bt;
        bt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
        step($urandom_range(0, 3) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 9) == 0,
             $urandom & 32'hFFFFFFFC, bt,
             $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
